// File: rtl/rob_multi_retire.sv
// Parametrised reorder buffer: allocates at tail, accepts NUM_CMP writebacks and retires up to
// RETIRE_W completed entries per cycle in program order from head; flush empties the buffer.
module rob_multi_retire #(
    parameter int DEPTH    = 16,
    parameter int NUM_CMP  = 3,
    parameter int RETIRE_W = 2,
    parameter int PREG_W   = 7,
    parameter int DATA_W   = 32,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    output logic [IDX_W-1:0]             alloc_rob_idx,
    input  logic [PREG_W-1:0]            alloc_preg_dst,
    input  logic [PREG_W-1:0]            alloc_old_preg,
    input  logic                         alloc_reg_write,
    input  logic                         alloc_mem_write,
    input  logic                         alloc_mem_to_reg,
    input  logic [NUM_CMP-1:0]           cmp_valid,
    input  logic [NUM_CMP*IDX_W-1:0]     cmp_rob_idx,
    input  logic [NUM_CMP*DATA_W-1:0]    cmp_data,
    input  logic                         flush,
    output logic [RETIRE_W-1:0]          ret_valid,
    output logic [RETIRE_W*PREG_W-1:0]   ret_preg_dst,
    output logic [RETIRE_W*PREG_W-1:0]   ret_old_preg,
    output logic [RETIRE_W*DATA_W-1:0]   ret_data,
    output logic [RETIRE_W-1:0]          ret_reg_write,
    output logic [RETIRE_W-1:0]          ret_mem_write,
    output logic [RETIRE_W-1:0]          ret_mem_to_reg,
    output logic [IDX_W:0]               count,
    output logic                         empty
);

    // Number of set bits in the retire vector; RETIRE_W <= DEPTH so IDX_W+1 bits always suffice.
    function automatic logic [IDX_W:0] popcount_f(input logic [RETIRE_W-1:0] vec);
        logic [IDX_W:0] sum;
        sum = {(IDX_W+1){1'b0}};
        for (int i = 0; i < RETIRE_W; i++) begin
            sum = sum + {{IDX_W{1'b0}}, vec[i]};
        end
        return sum;
    endfunction

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  complete_r;
    logic [PREG_W-1:0] preg_dst_r   [DEPTH];
    logic [PREG_W-1:0] old_preg_r   [DEPTH];
    logic [DATA_W-1:0] data_r       [DEPTH];
    logic [DEPTH-1:0]  reg_write_r;
    logic [DEPTH-1:0]  mem_write_r;
    logic [DEPTH-1:0]  mem_to_reg_r;

    logic [IDX_W:0]    head_r;
    logic [IDX_W:0]    tail_r;
    logic [IDX_W:0]    count_r;

    logic              full_s;
    logic              alloc_fire_s;
    logic [IDX_W-1:0]  tail_idx_s;
    logic [NUM_CMP-1:0] cmp_hit_s;
    logic [IDX_W-1:0]  cmp_idx_s    [NUM_CMP];
    logic [RETIRE_W-1:0] ret_valid_s;
    logic [IDX_W-1:0]  ret_idx_s    [RETIRE_W];
    logic [IDX_W:0]    ret_cnt_s;
    logic              chain_s;

    // Full when pointers share an index but differ in the wrap bit.
    always_comb begin
        full_s       = ((head_r ^ tail_r) == {1'b1, {IDX_W{1'b0}}});
        tail_idx_s   = tail_r[IDX_W-1:0];
        alloc_fire_s = alloc_valid & ~full_s & ~flush;
    end

    // Writebacks only land on live entries, so stale results after a flush are dropped.
    always_comb begin
        for (int p = 0; p < NUM_CMP; p++) begin
            cmp_idx_s[p] = cmp_rob_idx[p*IDX_W +: IDX_W];
            cmp_hit_s[p] = cmp_valid[p] & valid_r[cmp_idx_s[p]] & ~flush;
        end
    end

    // In-order retire chain: a slot retires only if every older slot also retires.
    always_comb begin
        chain_s = ~flush;
        for (int k = 0; k < RETIRE_W; k++) begin
            ret_idx_s[k]   = head_r[IDX_W-1:0] + IDX_W'(k);
            ret_valid_s[k] = chain_s & valid_r[ret_idx_s[k]] & complete_r[ret_idx_s[k]];
            chain_s        = ret_valid_s[k];
        end
        ret_cnt_s = popcount_f(ret_valid_s);
    end

    // Retire slot payload, taken straight from the entries at head+k.
    always_comb begin
        ret_valid = ret_valid_s;
        for (int k = 0; k < RETIRE_W; k++) begin
            ret_preg_dst[k*PREG_W +: PREG_W] = preg_dst_r[ret_idx_s[k]];
            ret_old_preg[k*PREG_W +: PREG_W] = old_preg_r[ret_idx_s[k]];
            ret_data[k*DATA_W +: DATA_W]     = data_r[ret_idx_s[k]];
            ret_reg_write[k]                 = reg_write_r[ret_idx_s[k]];
            ret_mem_write[k]                 = mem_write_r[ret_idx_s[k]];
            ret_mem_to_reg[k]                = mem_to_reg_r[ret_idx_s[k]];
        end
    end

    // Status outputs derived from registered state only.
    always_comb begin
        alloc_ready   = ~full_s;
        alloc_rob_idx = tail_idx_s;
        count         = count_r;
        empty         = (count_r == {(IDX_W+1){1'b0}});
    end

    // Entry status bits and pointers; allocation is applied last so it overrides a writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r    <= {DEPTH{1'b0}};
            complete_r <= {DEPTH{1'b0}};
            head_r     <= {(IDX_W+1){1'b0}};
            tail_r     <= {(IDX_W+1){1'b0}};
            count_r    <= {(IDX_W+1){1'b0}};
        end else if (flush) begin
            valid_r    <= {DEPTH{1'b0}};
            complete_r <= {DEPTH{1'b0}};
            head_r     <= {(IDX_W+1){1'b0}};
            tail_r     <= {(IDX_W+1){1'b0}};
            count_r    <= {(IDX_W+1){1'b0}};
        end else begin
            for (int p = 0; p < NUM_CMP; p++) begin
                if (cmp_hit_s[p]) begin
                    complete_r[cmp_idx_s[p]] <= 1'b1;
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (ret_valid_s[k]) begin
                    valid_r[ret_idx_s[k]]    <= 1'b0;
                    complete_r[ret_idx_s[k]] <= 1'b0;
                end
            end
            if (alloc_fire_s) begin
                valid_r[tail_idx_s]    <= 1'b1;
                complete_r[tail_idx_s] <= 1'b0;
                tail_r                 <= tail_r + {{IDX_W{1'b0}}, 1'b1};
            end
            head_r  <= head_r + ret_cnt_s;
            count_r <= count_r + {{IDX_W{1'b0}}, alloc_fire_s} - ret_cnt_s;
        end
    end

    // Payload storage needs no reset; the ascending port loop lets the highest port win.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_CMP; p++) begin
            if (cmp_hit_s[p]) begin
                data_r[cmp_idx_s[p]] <= cmp_data[p*DATA_W +: DATA_W];
            end
        end
        if (alloc_fire_s) begin
            preg_dst_r[tail_idx_s]   <= alloc_preg_dst;
            old_preg_r[tail_idx_s]   <= alloc_old_preg;
            reg_write_r[tail_idx_s]  <= alloc_reg_write;
            mem_write_r[tail_idx_s]  <= alloc_mem_write;
            mem_to_reg_r[tail_idx_s] <= alloc_mem_to_reg;
        end
    end

endmodule

// File: tb/tb_rob_multi_retire.sv
// Bench for rob_multi_retire: an input-driven reference model feeds a retire scoreboard,
// and scenario tasks check status outputs inline.
module tb_rob_multi_retire;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [3:0]  alloc_rob_idx;
    logic [6:0]  alloc_preg_dst = 7'd0;
    logic [6:0]  alloc_old_preg = 7'd0;
    logic        alloc_reg_write = 1'b0;
    logic        alloc_mem_write = 1'b0;
    logic        alloc_mem_to_reg = 1'b0;
    logic [2:0]  cmp_valid = 3'd0;
    logic [11:0] cmp_rob_idx = 12'd0;
    logic [95:0] cmp_data = 96'd0;
    logic        flush = 1'b0;
    logic [1:0]  ret_valid;
    logic [13:0] ret_preg_dst;
    logic [13:0] ret_old_preg;
    logic [63:0] ret_data;
    logic [1:0]  ret_reg_write;
    logic [1:0]  ret_mem_write;
    logic [1:0]  ret_mem_to_reg;
    logic [4:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    rob_multi_retire dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_idx(alloc_rob_idx),
        .alloc_preg_dst(alloc_preg_dst), .alloc_old_preg(alloc_old_preg),
        .alloc_reg_write(alloc_reg_write), .alloc_mem_write(alloc_mem_write),
        .alloc_mem_to_reg(alloc_mem_to_reg),
        .cmp_valid(cmp_valid), .cmp_rob_idx(cmp_rob_idx), .cmp_data(cmp_data),
        .flush(flush),
        .ret_valid(ret_valid), .ret_preg_dst(ret_preg_dst), .ret_old_preg(ret_old_preg),
        .ret_data(ret_data), .ret_reg_write(ret_reg_write), .ret_mem_write(ret_mem_write),
        .ret_mem_to_reg(ret_mem_to_reg), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [6:0] preg;
        logic [6:0] old;
        logic       rw;
        logic       mw;
        logic       m2r;
    } sb_t;

    sb_t         sb_q[$];
    bit [15:0]   mdl_valid = 16'd0;
    bit [15:0]   mdl_cmp = 16'd0;
    logic [31:0] mdl_data [16];
    int          mdl_head = 0;
    int          mdl_tail = 0;
    int          mdl_cnt = 0;

    function automatic void mdl_clear();
        mdl_valid = 16'd0;
        mdl_cmp   = 16'd0;
        mdl_head  = 0;
        mdl_tail  = 0;
        mdl_cnt   = 0;
        sb_q.delete();
    endfunction

    function automatic logic [1:0] exp_ret_f();
        logic [1:0] r;
        logic prev;
        int idx;
        r = 2'b00;
        prev = !flush && !reset;
        for (int k = 0; k < 2; k++) begin
            idx  = (mdl_head + k) % 16;
            prev = prev && mdl_valid[idx] && mdl_cmp[idx];
            r[k] = prev;
        end
        return r;
    endfunction

    // Reference model state update, driven only by the bench's own inputs.
    logic [1:0] m_ret;
    int         m_n;
    int         m_idx;
    bit         m_full;
    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            mdl_clear();
        end else begin
            m_ret  = exp_ret_f();
            m_full = (mdl_cnt == 16);
            for (int p = 0; p < 3; p++) begin
                if (cmp_valid[p]) begin
                    m_idx = int'(cmp_rob_idx[p*4 +: 4]);
                    if (mdl_valid[m_idx]) begin
                        mdl_cmp[m_idx]  = 1'b1;
                        mdl_data[m_idx] = cmp_data[p*32 +: 32];
                    end
                end
            end
            m_n = 0;
            for (int k = 0; k < 2; k++) begin
                if (m_ret[k]) begin
                    m_idx = (mdl_head + k) % 16;
                    mdl_valid[m_idx] = 1'b0;
                    mdl_cmp[m_idx]   = 1'b0;
                    m_n++;
                end
            end
            if (alloc_valid && !m_full) begin
                mdl_valid[mdl_tail] = 1'b1;
                mdl_cmp[mdl_tail]   = 1'b0;
                sb_q.push_back('{mdl_tail, alloc_preg_dst, alloc_old_preg,
                                 alloc_reg_write, alloc_mem_write, alloc_mem_to_reg});
                mdl_tail = (mdl_tail + 1) % 16;
                mdl_cnt  = mdl_cnt + 1;
            end
            mdl_head = (mdl_head + m_n) % 16;
            mdl_cnt  = mdl_cnt - m_n;
        end
    end

    // Retire scoreboard: compare the retire vector and pop one expected entry per retiring slot.
    logic [1:0] s_exp;
    sb_t        s_e;
    always @(negedge clk) begin
        if (!reset) begin
            s_exp = exp_ret_f();
            checks++;
            if (ret_valid !== s_exp) begin
                errors++;
                $display("FAIL ret_valid: got %b expected %b", ret_valid, s_exp);
            end
            for (int k = 0; k < 2; k++) begin
                if (s_exp[k]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_empty: got retire in slot %0d expected none queued", k);
                    end else begin
                        s_e = sb_q.pop_front();
                        if (ret_preg_dst[k*7 +: 7] !== s_e.preg || ret_old_preg[k*7 +: 7] !== s_e.old ||
                            ret_data[k*32 +: 32] !== mdl_data[s_e.idx] || ret_reg_write[k] !== s_e.rw ||
                            ret_mem_write[k] !== s_e.mw || ret_mem_to_reg[k] !== s_e.m2r) begin
                            errors++;
                            $display("FAIL ret_slot%0d: got preg %0h old %0h data %0h flags %b%b%b expected preg %0h old %0h data %0h flags %b%b%b",
                                     k, ret_preg_dst[k*7 +: 7], ret_old_preg[k*7 +: 7], ret_data[k*32 +: 32],
                                     ret_reg_write[k], ret_mem_write[k], ret_mem_to_reg[k],
                                     s_e.preg, s_e.old, mdl_data[s_e.idx], s_e.rw, s_e.mw, s_e.m2r);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        alloc_valid = 1'b0;
        cmp_valid   = 3'd0;
        flush       = 1'b0;
    endtask

    task automatic set_alloc(input logic [6:0] p, input logic [6:0] o);
        alloc_valid      = 1'b1;
        alloc_preg_dst   = p;
        alloc_old_preg   = o;
        alloc_reg_write  = p[0];
        alloc_mem_write  = o[0];
        alloc_mem_to_reg = p[1];
    endtask

    task automatic set_cmp(input int port, input int idx, input logic [31:0] d);
        cmp_valid[port]            = 1'b1;
        cmp_rob_idx[port*4 +: 4]   = 4'(idx);
        cmp_data[port*32 +: 32]    = d;
    endtask

    task automatic test_reset();
        clr_inputs();
        #1 reset = 1'b1;
        tick();
        checks++;
        if (alloc_ready !== 1'b1 || alloc_rob_idx !== 4'd0 || ret_valid !== 2'b00 ||
            empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: got ready %b idx %0d ret %b empty %b count %0d expected 1 0 00 1 0",
                     alloc_ready, alloc_rob_idx, ret_valid, empty, count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill_and_full_retire();
        for (int i = 0; i < 16; i++) begin
            set_alloc(7'(i + 16), 7'(i + 32));
            checks++;
            if (alloc_rob_idx !== 4'(i) || alloc_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_idx: got idx %0d ready %b expected idx %0d ready 1", alloc_rob_idx, alloc_ready, i);
            end
            tick();
        end
        clr_inputs();
        checks++;
        if (alloc_ready !== 1'b0 || count !== 5'd16 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got ready %b count %0d empty %b expected 0 16 0", alloc_ready, count, empty);
        end
        set_cmp(0, 0, 32'h1234_0000);
        tick();
        clr_inputs();
        set_alloc(7'h55, 7'h2a);
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || ret_valid !== 2'b01) begin
            errors++;
            $display("FAIL full_retire_cycle: got ready %b ret %b expected ready 0 ret 01", alloc_ready, ret_valid);
        end
        tick();
        checks++;
        if (count !== 5'd15 || alloc_ready !== 1'b1 || alloc_rob_idx !== 4'd0) begin
            errors++;
            $display("FAIL full_after_retire: got count %0d ready %b idx %0d expected 15 1 0", count, alloc_ready, alloc_rob_idx);
        end
        tick();
        clr_inputs();
        checks++;
        if (count !== 5'd16 || alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_realloc: got count %0d ready %b expected 16 0", count, alloc_ready);
        end
        flush = 1'b1;
        tick();
        clr_inputs();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL full_flush: got count %0d empty %b expected 0 1", count, empty);
        end
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 4; i++) begin
            set_alloc(7'(i + 64), 7'(i + 80));
            tick();
        end
        clr_inputs();
        set_cmp(0, 2, 32'hC0DE_0002);
        set_cmp(1, 3, 32'hC0DE_0003);
        tick();
        clr_inputs();
        tick();
        checks++;
        if (ret_valid !== 2'b00) begin
            errors++;
            $display("FAIL order_blocked: got %b expected 00", ret_valid);
        end
        set_cmp(2, 0, 32'hC0DE_0000);
        tick();
        clr_inputs();
        checks++;
        if (ret_valid !== 2'b01) begin
            errors++;
            $display("FAIL order_head_only: got %b expected 01", ret_valid);
        end
        tick();
        checks++;
        if (ret_valid !== 2'b00) begin
            errors++;
            $display("FAIL order_stop_at_1: got %b expected 00", ret_valid);
        end
        set_cmp(0, 1, 32'hC0DE_0001);
        tick();
        clr_inputs();
        checks++;
        if (ret_valid !== 2'b11) begin
            errors++;
            $display("FAIL order_dual: got %b expected 11", ret_valid);
        end
        tick();
        checks++;
        if (ret_valid !== 2'b01) begin
            errors++;
            $display("FAIL order_last: got %b expected 01", ret_valid);
        end
        tick();
        checks++;
        if (ret_valid !== 2'b00 || count !== 5'd0 || alloc_rob_idx !== 4'd4 || empty !== 1'b1) begin
            errors++;
            $display("FAIL order_drained: got ret %b count %0d idx %0d empty %b expected 00 0 4 1",
                     ret_valid, count, alloc_rob_idx, empty);
        end
    endtask

    task automatic test_port_priority();
        set_alloc(7'h11, 7'h21);
        tick();
        set_alloc(7'h12, 7'h22);
        tick();
        clr_inputs();
        set_cmp(1, 4, 32'h0000_1111);
        set_cmp(0, 5, 32'h0000_AAAA);
        set_cmp(2, 5, 32'h0000_BBBB);
        tick();
        clr_inputs();
        checks++;
        if (ret_valid !== 2'b11 || ret_data[63:32] !== 32'h0000_BBBB || ret_data[31:0] !== 32'h0000_1111) begin
            errors++;
            $display("FAIL port_priority: got ret %b data %0h/%0h expected 11 bbbb/1111",
                     ret_valid, ret_data[63:32], ret_data[31:0]);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL port_drain: got empty %b expected 1", empty);
        end
    endtask

    task automatic test_wrap();
        int pend[$];
        for (int i = 0; i < 42; i++) begin
            clr_inputs();
            if (pend.size() != 0) begin
                set_cmp(i % 3, pend.pop_front(), $urandom);
            end
            if (i < 40) begin
                checks++;
                if (alloc_rob_idx !== 4'((6 + i) % 16)) begin
                    errors++;
                    $display("FAIL wrap_idx: got %0d expected %0d", alloc_rob_idx, (6 + i) % 16);
                end
                set_alloc(7'($urandom_range(0, 127)), 7'(i + 40));
                pend.push_back((6 + i) % 16);
            end
            tick();
        end
        clr_inputs();
        repeat (3) tick();
        checks++;
        if (count !== 5'd0 || alloc_rob_idx !== 4'd14) begin
            errors++;
            $display("FAIL wrap_drained: got count %0d idx %0d expected 0 14", count, alloc_rob_idx);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            set_alloc(7'(i + 100), 7'(i + 110));
            tick();
        end
        clr_inputs();
        set_cmp(0, 15, 32'hF00F_0015);
        set_cmp(2, 2, 32'hF00F_0002);
        tick();
        clr_inputs();
        checks++;
        if (ret_valid !== 2'b00 || count !== 5'd6) begin
            errors++;
            $display("FAIL flush_pre: got ret %b count %0d expected 00 6", ret_valid, count);
        end
        set_cmp(1, 14, 32'hF00F_0014);
        tick();
        clr_inputs();
        flush = 1'b1;
        #1;
        checks++;
        if (ret_valid !== 2'b00) begin
            errors++;
            $display("FAIL flush_gates_retire: got %b expected 00", ret_valid);
        end
        tick();
        clr_inputs();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || ret_valid !== 2'b00 || alloc_rob_idx !== 4'd0) begin
            errors++;
            $display("FAIL flush_state: got count %0d empty %b ret %b idx %0d expected 0 1 00 0",
                     count, empty, ret_valid, alloc_rob_idx);
        end
        set_alloc(7'h3c, 7'h4d);
        set_cmp(0, 0, 32'hDEAD_0000);
        set_cmp(1, 3, 32'hDEAD_0003);
        tick();
        clr_inputs();
        tick();
        checks++;
        if (count !== 5'd1 || ret_valid !== 2'b00) begin
            errors++;
            $display("FAIL flush_stale: got count %0d ret %b expected 1 00", count, ret_valid);
        end
        set_cmp(2, 0, 32'h0000_5555);
        tick();
        clr_inputs();
        checks++;
        if (ret_valid !== 2'b01 || ret_data[31:0] !== 32'h0000_5555 || ret_old_preg[6:0] !== 7'h4d) begin
            errors++;
            $display("FAIL flush_next: got ret %b data %0h old %0h expected 01 5555 4d",
                     ret_valid, ret_data[31:0], ret_old_preg[6:0]);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain: got empty %b expected 1", empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(7'(i + 7), 7'(i + 9));
            tick();
        end
        clr_inputs();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || alloc_rob_idx !== 4'd0 || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got count %0d empty %b idx %0d ready %b expected 0 1 0 1",
                     count, empty, alloc_rob_idx, alloc_ready);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        mdl_clear();
        test_reset();
        test_fill_and_full_retire();
        test_in_order();
        test_port_priority();
        test_wrap();
        test_flush();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
